pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor: generalises the team's 4-bit combinational full-adder chain to WIDTH bits, split into STAGES registered carry-chain segments, with add/subtract mode, carry/borrow-in, signed overflow and a valid/ready handshake. Sits in the datapath wherever wide additions would break timing as a single combinational chain. One result per cycle at full throughput.

---
 rtl/pipelined_adder.sv | 109 ++++++++++
 tb/tb_pipelined_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES registered
// carry-chain segments, with signed overflow and a valid/ready handshake.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned CW    = CHUNK + 1;
    localparam int unsigned MSB   = WIDTH - 1;

    // Per-stage registers; operands travel with the beat so later stages can add their chunk.
    logic             vld_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] bp_q    [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q;

    logic             src_vld [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_c   [STAGES];

    logic             vld_d   [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] bp_d    [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_d [STAGES];
    logic             ovf_d;
    logic [CW-1:0]    part;
    logic             adv;

    // Next-state for every stage: each adds its own chunk on top of what its predecessor holds.
    always_comb begin
        adv        = out_ready || !vld_q[STAGES-1];
        part       = '0;
        src_vld[0] = in_valid;
        src_a[0]   = a;
        src_b[0]   = sub ? ~b : b;
        src_sum[0] = '0;
        src_c[0]   = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = bp_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = carry_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + CW'(src_c[k]);
            vld_d[k]                    = src_vld[k];
            a_d[k]                      = src_a[k];
            bp_d[k]                     = src_b[k];
            sum_d[k]                    = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
            carry_d[k]                  = part[CHUNK];
        end
        ovf_d = (src_a[STAGES-1][MSB] == src_b[STAGES-1][MSB])
             && (sum_d[STAGES-1][MSB] != src_a[STAGES-1][MSB]);
    end

    // The whole pipeline advances or holds as one; bubbles move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= 1'b0;
                a_q[k]     <= '0;
                bp_q[k]    <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= vld_d[k];
                a_q[k]     <= a_d[k];
                bp_q[k]    <= bp_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, streaming,
// random back-pressure, mid-stream reset and two parameter variants.
module tb_pipelined_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned S  = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;

    logic          v8, r8, ov8, or8, c8, o8;
    logic [7:0]    a8, b8, s8;
    logic          v32, r32, ov32, or32, c32, o32;
    logic [31:0]   a32, b32, s32;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_out = 0;
    bit            mon_en = 1'b0;
    bit            stalled_prev = 1'b0;
    logic [17:0]   held;
    logic [17:0]   q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(1'b1), .sub(1'b0), .out_valid(ov8),
        .out_ready(or8), .sum(s8), .cout(c8), .ovf(o8));

    pipelined_adder #(.WIDTH(32), .STAGES(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32),
        .a(a32), .b(b32), .cin(1'b1), .sub(1'b0), .out_valid(ov32),
        .out_ready(or32), .sum(s32), .cout(c32), .ovf(o32));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} for one beat.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yp;
        logic [16:0] r;
        logic        o;
        yp = sb ? ~y : y;
        r  = 17'(x) + 17'(yp) + 17'(ci ^ sb);
        o  = (x[15] == yp[15]) && (r[15] != x[15]);
        return {o, r};
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [17:0] e;
            chk("in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
            if (stalled_prev) chk("stall_hold", {13'd0, out_valid, ovf, cout, sum}, {13'd0, 1'b1, held});
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream_beat", 32'({ovf, cout, sum}), 32'(e));
                    n_out++;
                end
            end
            stalled_prev = out_valid && !out_ready;
            held = {ovf, cout, sum};
        end
    end

    task automatic send_one(input vec_t v, input int idx);
        int n;
        @(posedge clk); #1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++; #1;
            if (n == 1) in_valid = 1'b0;
        end while (!out_valid && n < 20);
        chk($sformatf("vec%0d_latency", idx), 32'(n), 32'(S));
        chk($sformatf("vec%0d_sum", idx), 32'(sum), 32'(v.sum));
        chk($sformatf("vec%0d_cout", idx), 32'(cout), 32'(v.cout));
        chk($sformatf("vec%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   base, cnt, n8, n32;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
        v32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {13'd0, in_ready, out_valid, ovf, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        rst = 1'b0;
        mon_en = 1'b1;

        // Directed table, one beat at a time.
        for (int i = 0; i < 8; i++) send_one(vecs[i], i);

        // Back-to-back stream at full rate.
        @(posedge clk); #1;
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (S) @(posedge clk);
        #1;
        chk("stream_count", 32'(n_out - base), 32'd100);
        drain();

        // Random valid and back-pressure.
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'(i + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        mon_en = 1'b0; stalled_prev = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async", {13'd0, in_ready, out_valid, ovf, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("rst_no_ghost", 32'(cnt), 32'd0);
        send_one(vecs[0], 8);

        // Parameter variants: max + max + 1.
        mon_en = 1'b0;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; v32 = 1'b1;
        n8 = 0; n32 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            v8 = 1'b0; v32 = 1'b0;
            if (ov8 && n8 == 0) begin
                n8 = n;
                chk("w8_result", {23'd0, o8, c8, s8}, {23'd0, 1'b0, 1'b1, 8'hFF});
            end
            if (ov32 && n32 == 0) begin
                n32 = n;
                chk("w32_sum", s32, 32'hFFFF_FFFF);
                chk("w32_flags", {30'd0, o32, c32}, {30'd0, 1'b0, 1'b1});
            end
        end
        chk("w8_latency", 32'(n8), 32'd1);
        chk("w32_latency", 32'(n32), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
